// File: rtl/btn_event_sched_if.sv
// ---------------------------------------------------------------------------
// btn_event_sched_if
//
// Event channel between btn_event_sched (master) and the command/display
// logic that consumes button events (slave).
//
// Handshake: an event transfers on every rising clk edge where evt_valid
// and evt_ready are both 1. Once evt_valid is raised, it stays high and
// evt_id/evt_type stay stable until that transfer edge. evt_ready may be
// driven freely and does not depend on evt_valid. evt_drop is a
// side-band, one-cycle pulse that is not part of the handshake.
//
// Signals:
//   evt_valid  master->slave  event available on evt_id/evt_type
//   evt_ready  slave->master  consumer accepts the event this cycle
//   evt_id     master->slave  index of the button that raised the event
//   evt_type   master->slave  00 press, 01 release, 10 long, 11 repeat
//   evt_drop   master->slave  pulse: an event was discarded (slot full)
// ---------------------------------------------------------------------------
interface btn_event_sched_if #(
    parameter int ID_W = 2
);
    logic            evt_valid;
    logic            evt_ready;
    logic [ID_W-1:0] evt_id;
    logic [1:0]      evt_type;
    logic            evt_drop;

    modport master (
        output evt_valid,
        output evt_id,
        output evt_type,
        output evt_drop,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_id,
        input  evt_type,
        input  evt_drop,
        output evt_ready
    );
endinterface

// File: rtl/btn_event_sched.sv
// ---------------------------------------------------------------------------
// btn_event_sched
//
// Turns N_BTN debounced button levels into discrete events (press, release,
// long press and optional auto-repeat). Each button runs its own small FSM
// and posts into a one-deep pending slot; a round-robin arbiter moves full
// slots onto a single valid/ready event channel.
//
// Optional feature macro: BTN_REPEAT_EN
//   defined   : HELD emits a repeat event every REPEAT_CYCLES cycles.
//   undefined : HELD only waits for release, its counter is frozen and
//               REPEAT_CYCLES is ignored.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   btn_state    in   [N_BTN] debounced levels, 1 = pressed, clk-synchronous
//   evt          if   btn_event_sched_if.master event channel
//                     (evt_valid, evt_ready, evt_id, evt_type, evt_drop)
//   dbg_state_o  out  [2*N_BTN] per-button FSM state, button i at [2i+1:2i]
// ---------------------------------------------------------------------------
module btn_event_sched #(
    parameter int               N_BTN         = 4,
    parameter int               ID_W          = 2,
    parameter int               CNT_W         = 24,
    parameter logic [CNT_W-1:0] LONG_CYCLES   = 24'd5_000_000,
    parameter logic [CNT_W-1:0] REPEAT_CYCLES = 24'd1_000_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_BTN-1:0]       btn_state,
    btn_event_sched_if.master      evt,
    output logic [2*N_BTN-1:0]     dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PRESSED = 2'b01,
        ST_HELD    = 2'b10
    } state_e;

    localparam logic [1:0] EVT_PRESS   = 2'b00;
    localparam logic [1:0] EVT_RELEASE = 2'b01;
    localparam logic [1:0] EVT_LONG    = 2'b10;

    localparam logic [CNT_W-1:0] LONG_LAST = LONG_CYCLES - 1'b1;

`ifdef BTN_REPEAT_EN
    localparam logic [1:0]       EVT_REPEAT  = 2'b11;
    localparam logic [CNT_W-1:0] REPEAT_LAST = REPEAT_CYCLES - 1'b1;
`else
    // Repeat is compiled out; the parameter is kept only for a uniform
    // instantiation interface.
    logic unused_repeat;
    assign unused_repeat = ^REPEAT_CYCLES;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e             state_q     [N_BTN];
    state_e             state_d     [N_BTN];
    logic [CNT_W-1:0]   cnt_q       [N_BTN];
    logic [CNT_W-1:0]   cnt_d       [N_BTN];
    logic [N_BTN-1:0]   btn_prev_q;

    logic [N_BTN-1:0]   slot_full_q;
    logic [N_BTN-1:0]   slot_full_d;
    logic [1:0]         slot_type_q [N_BTN];
    logic [1:0]         slot_type_d [N_BTN];

    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    ptr_d;

    logic               evt_valid_q;
    logic               evt_valid_d;
    logic [ID_W-1:0]    evt_id_q;
    logic [ID_W-1:0]    evt_id_d;
    logic [1:0]         evt_type_q;
    logic [1:0]         evt_type_d;
    logic               evt_drop_q;
    logic               evt_drop_d;

    // Per-button post requests from the FSMs
    logic [N_BTN-1:0]   post;
    logic [1:0]         post_type   [N_BTN];

    // Arbiter results
    logic               load;
    logic               grant_vld;
    logic [ID_W-1:0]    grant_id;
    logic [N_BTN-1:0]   grant_oh;
    logic               hi_vld;
    logic [ID_W-1:0]    hi_id;
    logic               lo_vld;
    logic [ID_W-1:0]    lo_id;

    // ------------------------------------------------------------------
    // Per-button FSMs: next state, counter and post request
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i]   = state_q[i];
            cnt_d[i]     = cnt_q[i];
            post[i]      = 1'b0;
            post_type[i] = EVT_PRESS;

            case (state_q[i])
                ST_IDLE: begin
                    if (btn_state[i] && !btn_prev_q[i]) begin
                        post[i]      = 1'b1;
                        post_type[i] = EVT_PRESS;
                        cnt_d[i]     = '0;
                        state_d[i]   = ST_PRESSED;
                    end
                end

                ST_PRESSED: begin
                    // Release wins over a long press on the same edge.
                    if (!btn_state[i]) begin
                        post[i]      = 1'b1;
                        post_type[i] = EVT_RELEASE;
                        cnt_d[i]     = '0;
                        state_d[i]   = ST_IDLE;
                    end else if (cnt_q[i] == LONG_LAST) begin
                        post[i]      = 1'b1;
                        post_type[i] = EVT_LONG;
                        cnt_d[i]     = '0;
                        state_d[i]   = ST_HELD;
                    end else begin
                        cnt_d[i]     = cnt_q[i] + 1'b1;
                    end
                end

                ST_HELD: begin
                    if (!btn_state[i]) begin
                        post[i]      = 1'b1;
                        post_type[i] = EVT_RELEASE;
                        cnt_d[i]     = '0;
                        state_d[i]   = ST_IDLE;
                    end
`ifdef BTN_REPEAT_EN
                    else if (cnt_q[i] == REPEAT_LAST) begin
                        post[i]      = 1'b1;
                        post_type[i] = EVT_REPEAT;
                        cnt_d[i]     = '0;
                    end else begin
                        cnt_d[i]     = cnt_q[i] + 1'b1;
                    end
`endif
                end

                default: begin
                    state_d[i] = ST_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter and output register next state.
    // The search is split in two: the lowest full slot at or above the
    // pointer (hi), else the lowest full slot overall (lo, the wrap case).
    // ------------------------------------------------------------------
    always_comb begin
        hi_vld = 1'b0;
        hi_id  = '0;
        lo_vld = 1'b0;
        lo_id  = '0;
        // Walk downward so the lowest matching index is the last written.
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (slot_full_q[i]) begin
                lo_vld = 1'b1;
                lo_id  = ID_W'(i);
                if (ID_W'(i) >= ptr_q) begin
                    hi_vld = 1'b1;
                    hi_id  = ID_W'(i);
                end
            end
        end

        grant_vld = hi_vld | lo_vld;
        grant_id  = hi_vld ? hi_id : lo_id;
        load      = !evt_valid_q || evt.evt_ready;

        grant_oh    = '0;
        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
        evt_type_d  = evt_type_q;
        ptr_d       = ptr_q;

        if (load) begin
            evt_valid_d = grant_vld;
            if (grant_vld) begin
                evt_id_d = grant_id;
                ptr_d    = (grant_id == ID_W'(N_BTN - 1)) ? '0 : grant_id + 1'b1;
                for (int i = 0; i < N_BTN; i++) begin
                    if (grant_id == ID_W'(i)) begin
                        grant_oh[i] = 1'b1;
                        evt_type_d  = slot_type_q[i];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending slots. A slot being granted on this edge is free for a new
    // post on the same edge, so that case is not a drop.
    // ------------------------------------------------------------------
    always_comb begin
        slot_full_d = slot_full_q;
        evt_drop_d  = 1'b0;
        for (int i = 0; i < N_BTN; i++) begin
            slot_type_d[i] = slot_type_q[i];
            if (post[i]) begin
                if (!slot_full_q[i] || grant_oh[i]) begin
                    slot_full_d[i] = 1'b1;
                    slot_type_d[i] = post_type[i];
                end else begin
                    evt_drop_d = 1'b1;
                end
            end else if (grant_oh[i]) begin
                slot_full_d[i] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i]     <= ST_IDLE;
                cnt_q[i]       <= '0;
                slot_type_q[i] <= 2'b00;
            end
            btn_prev_q  <= '0;
            slot_full_q <= '0;
            ptr_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            evt_type_q  <= 2'b00;
            evt_drop_q  <= 1'b0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i]     <= state_d[i];
                cnt_q[i]       <= cnt_d[i];
                slot_type_q[i] <= slot_type_d[i];
            end
            btn_prev_q  <= btn_state;
            slot_full_q <= slot_full_d;
            ptr_q       <= ptr_d;
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
            evt_type_q  <= evt_type_d;
            evt_drop_q  <= evt_drop_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign evt.evt_valid = evt_valid_q;
    assign evt.evt_id    = evt_id_q;
    assign evt.evt_type  = evt_type_q;
    assign evt.evt_drop  = evt_drop_q;

    always_comb begin
        dbg_state_o = '0;
        for (int i = 0; i < N_BTN; i++) begin
            dbg_state_o[2*i +: 2] = state_q[i];
        end
    end

endmodule

// File: tb/tb_btn_event_sched.sv
// ---------------------------------------------------------------------------
// tb_btn_event_sched
//
// Self-checking bench for btn_event_sched with N_BTN=4, LONG_CYCLES=10,
// REPEAT_CYCLES=8. Expected events ({cycle, id, type}) are queued when
// stimulus is driven and compared as the DUT hands them over; a nonzero
// cycle field also pins the transfer cycle. Inputs change 1 time unit
// after a rising edge; outputs are sampled on falling edges.
// ---------------------------------------------------------------------------
module tb_btn_event_sched;

    localparam int               N_BTN         = 4;
    localparam int               ID_W          = 2;
    localparam int               CNT_W         = 24;
    localparam logic [CNT_W-1:0] LONG_CYCLES   = 24'd10;
    localparam logic [CNT_W-1:0] REPEAT_CYCLES = 24'd8;

    localparam logic [1:0] T_PRESS   = 2'b00;
    localparam logic [1:0] T_RELEASE = 2'b01;
    localparam logic [1:0] T_LONG    = 2'b10;
    localparam logic [1:0] T_REPEAT  = 2'b11;

    // ---------------- clock / reset ----------------
    logic               clk = 1'b0;
    logic               rst_n;
    logic [N_BTN-1:0]   btn_state;
    logic [2*N_BTN-1:0] dbg_state;

    btn_event_sched_if #(.ID_W(ID_W)) evt_if ();

    btn_event_sched #(
        .N_BTN         (N_BTN),
        .ID_W          (ID_W),
        .CNT_W         (CNT_W),
        .LONG_CYCLES   (LONG_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_state   (btn_state),
        .evt         (evt_if),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [19:0] exp_q[$];
    int err_cnt    = 0;
    int chk_cnt    = 0;
    int valid_seen = 0;
    int drop_seen  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_evt(input int id, input logic [1:0] typ, input int c);
        logic [15:0] c16;
        c16 = 16'(c);
        exp_q.push_back({c16, 2'(id), typ});
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (evt_if.evt_drop)  drop_seen++;
            if (evt_if.evt_valid) valid_seen++;
            if (evt_if.evt_valid && evt_if.evt_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_evt", 32'(exp_q.size()), 32'd1);
                end else begin
                    logic [19:0] e;
                    logic [15:0] c16;
                    e   = exp_q.pop_front();
                    c16 = cyc[15:0];
                    check_eq("evt", 32'({evt_if.evt_id, evt_if.evt_type}), 32'(e[3:0]));
                    if (e[19:4] != 16'd0) check_eq("evt_cyc", 32'(c16), 32'(e[19:4]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n     = 1'b0;
        btn_state = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    // Short press (h < LONG_CYCLES) of one button: press then release.
    task automatic press_hold(input int id, input int h);
        int t0;
        @(posedge clk); #1;
        btn_state[id] = 1'b1;
        t0 = cyc;
        push_evt(id, T_PRESS,   t0 + 2);
        push_evt(id, T_RELEASE, t0 + h + 2);
        repeat (h) @(posedge clk);
        #1 btn_state[id] = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", err_cnt + 1, chk_cnt + 1);
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int t0;
        int base;
        logic [8:0] seq;
        logic [8:0] drop_exp;

        evt_if.evt_ready = 1'b1;
        btn_state        = '0;
        rst_n            = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_valid", 32'(evt_if.evt_valid), 32'd0);
        check_eq("rst_id",    32'(evt_if.evt_id),    32'd0);
        check_eq("rst_type",  32'(evt_if.evt_type),  32'd0);
        check_eq("rst_drop",  32'(evt_if.evt_drop),  32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle: no events for 100 cycles
        base = valid_seen;
        repeat (100) @(negedge clk);
        check_eq("idle_no_evt", 32'(valid_seen - base), 32'd0);

        // Button 2 for 5 cycles: press, release, no long; press latency
        @(posedge clk); #1;
        btn_state[2] = 1'b1;
        t0 = cyc;
        push_evt(2, T_PRESS,   t0 + 2);
        push_evt(2, T_RELEASE, t0 + 7);
        @(negedge clk);
        @(negedge clk);
        check_eq("press_lat_e0", 32'(evt_if.evt_valid), 32'd0);
        @(negedge clk);
        check_eq("press_lat_e1", 32'(evt_if.evt_valid), 32'd1);
        repeat (3) @(posedge clk);
        #1 btn_state[2] = 1'b0;
        wait_drain(30);

        // Button 1 held 40 cycles: press, long, (repeats), release
        @(posedge clk); #1;
        btn_state[1] = 1'b1;
        t0 = cyc;
        push_evt(1, T_PRESS, t0 + 2);
        push_evt(1, T_LONG,  t0 + 12);
`ifdef BTN_REPEAT_EN
        push_evt(1, T_REPEAT, t0 + 20);
        push_evt(1, T_REPEAT, t0 + 28);
        push_evt(1, T_REPEAT, t0 + 36);
`endif
        push_evt(1, T_RELEASE, t0 + 42);
        repeat (40) @(posedge clk);
        #1 btn_state[1] = 1'b0;
        wait_drain(30);

        // Random short presses, one button at a time
        for (int k = 0; k < 4; k++) begin
            press_hold(int'($urandom_range(0, N_BTN - 1)), int'($urandom_range(2, 8)));
            wait_drain(30);
        end

        // All four on one edge, pointer 0: order 0,1,2,3 back to back
        apply_reset();
        @(posedge clk); #1;
        btn_state = 4'b1111;
        t0 = cyc;
        for (int k = 0; k < 4; k++) push_evt(k, T_PRESS,   t0 + 2 + k);
        for (int k = 0; k < 4; k++) push_evt(k, T_RELEASE, t0 + 10 + k);
        repeat (8) @(posedge clk);
        #1 btn_state = '0;
        wait_drain(40);

        // Move pointer to 2 via button 1, then all four: order 2,3,0,1
        press_hold(1, 3);
        wait_drain(30);
        @(posedge clk); #1;
        btn_state = 4'b1111;
        t0 = cyc;
        for (int k = 0; k < 4; k++) push_evt((k + 2) % 4, T_PRESS,   t0 + 2 + k);
        for (int k = 0; k < 4; k++) push_evt((k + 2) % 4, T_RELEASE, t0 + 10 + k);
        repeat (8) @(posedge clk);
        #1 btn_state = '0;
        wait_drain(40);

        // Backpressure on button 3: held output, full slot, two drops
        seq      = 9'b000110011;
        drop_exp = 9'b010100000;
        push_evt(3, T_PRESS,   0);
        push_evt(3, T_RELEASE, 0);
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            if (k == 0) evt_if.evt_ready = 1'b0;
            btn_state[3] = seq[k];
            @(negedge clk);
            check_eq($sformatf("drop_step%0d", k), 32'(evt_if.evt_drop), 32'(drop_exp[k]));
            if (k >= 2) begin
                check_eq("hold_valid", 32'(evt_if.evt_valid), 32'd1);
                check_eq("hold_id",    32'(evt_if.evt_id),    32'd3);
                check_eq("hold_type",  32'(evt_if.evt_type),  32'(T_PRESS));
            end
        end
        @(posedge clk); #1;
        evt_if.evt_ready = 1'b1;
        wait_drain(20);

        // Reset while an event is held and slots are full
        @(posedge clk); #1;
        evt_if.evt_ready = 1'b0;
        btn_state        = 4'b0111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("pre_rst_valid", 32'(evt_if.evt_valid), 32'd1);
        #2;
        rst_n     = 1'b0;
        btn_state = '0;
        #1;
        check_eq("mid_rst_valid", 32'(evt_if.evt_valid), 32'd0);
        check_eq("mid_rst_drop",  32'(evt_if.evt_drop),  32'd0);
        check_eq("mid_rst_id",    32'(evt_if.evt_id),    32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n            = 1'b1;
        evt_if.evt_ready = 1'b1;
        base = valid_seen;
        repeat (30) @(negedge clk);
        check_eq("post_rst_no_evt", 32'(valid_seen - base), 32'd0);

        check_eq("drop_total", 32'(drop_seen), 32'd2);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/btn_event_sched.md
# btn_event_sched

Event controller that sits behind a bank of per-button debouncers and turns their debounced level outputs into discrete, timestamp-free button events. Each button has its own press, long-press and (optionally) auto-repeat state machine. Pending events from all buttons are shared onto one valid/ready event channel by a round-robin arbiter. The channel feeds the project's command/display logic, so that logic consumes one event at a time instead of polling N levels.

## Interface
- `N_BTN`, 4: number of debounced button inputs, 2..16.
- `ID_W`, 2: width of event id; must satisfy 2^ID_W >= N_BTN.
- `CNT_W`, 24: width of the per-button hold counter.
- `LONG_CYCLES`, 24'd5_000_000: cycles in PRESSED before a long-press event; must be >= 2.
- `REPEAT_CYCLES`, 24'd1_000_000: cycles between repeat events in HELD; must be >= 2.

- `clk`  in  1  system clock; all state is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_state`  in  N_BTN  debounced levels, 1 = pressed; already synchronous to `clk`.
- `evt_valid`  out  1  event available on `evt_id`/`evt_type`.
- `evt_ready`  in  1  consumer accepts the event this cycle.
- `evt_id`  out  ID_W  index of the button that generated the event.
- `evt_type`  out  2  event kind: 00 press, 01 release, 10 long, 11 repeat.
- `evt_drop`  out  1  one-cycle pulse: an event was discarded because that button's pending slot was full.

## Operation
- Reset values: `evt_valid`=0, `evt_id`=0, `evt_type`=00, `evt_drop`=0. All per-button FSMs are IDLE, counters 0, `btn_prev` 0, pending slots empty, round-robin pointer 0.
- Per-button FSM states:
  - IDLE: on a rising edge of `btn_state[i]` (`btn_state[i]`=1, `btn_prev[i]`=0), post press, clear counter, go to PRESSED.
  - PRESSED: counter increments each cycle. When counter == LONG_CYCLES-1, post long, clear counter, go to HELD.
  - HELD: counter increments. With repeat enabled, when counter == REPEAT_CYCLES-1, post repeat and clear counter.
  - Any non-IDLE state: `btn_state[i]`=0 posts release and returns to IDLE. Release takes priority over long/repeat in the same cycle.
- Pending slots:
  - Each button has a one-deep pending slot holding a type.
  - Posting to an empty slot fills it.
  - Posting to a full slot that is not being granted that cycle: the event is discarded and `evt_drop` pulses. FSM state still advances.
- Arbiter:
  - The output register loads when `evt_valid`=0 or `evt_ready`=1.
  - It grants the first full slot searching from the pointer upward, with wrap-around. The granted slot empties.
  - The pointer becomes (granted id + 1) mod N_BTN.
  - If no slot is full, `evt_valid` deasserts on the transfer edge.
- Simultaneous events: a slot granted and posted on the same edge ends full with the new event; no drop.
- While `evt_valid`=1 and `evt_ready`=0, `evt_id`/`evt_type` are held stable.
- Reset asserted mid-operation clears everything immediately. Events pending or in flight are lost, with no drop pulse.

## Timing
- Press latency:
  - edge E0 samples the rising edge and fills the slot;
  - edge E1 loads the output if the output register is free;
  - `evt_valid` is high after E1.
- Long event: posted on the edge where the PRESSED counter reaches LONG_CYCLES-1, i.e. LONG_CYCLES edges after the press edge.
- Repeat event: posted every REPEAT_CYCLES edges in HELD.
- Throughput: one event per cycle while `evt_ready`=1.
- `evt_drop` is registered and asserts the cycle after the discarding edge.

## Configuration
- `BTN_REPEAT_EN` defined:
  - HELD posts repeat events every REPEAT_CYCLES.
  - The counter keeps running in HELD.
- Undefined:
  - No repeat logic. HELD waits only for release.
  - The counter is frozen in HELD.
  - Type 11 is never produced.
  - The REPEAT_CYCLES parameter is ignored.

## Test plan
- Reset with `btn_state`=4'b0000, then release reset -> all outputs 0. No event for 100 cycles.
- Press button 2 (LONG_CYCLES=10) for 5 cycles, `evt_ready`=1 -> press id 2 then release id 2 on `evt_type`. No long event.
- Hold button 1 for 40 cycles (LONG_CYCLES=10, REPEAT_CYCLES=8, `BTN_REPEAT_EN`) -> press, long at 10 cycles, repeats at 18, 26, 34, then release. Without the macro: press, long, release only.
- Press buttons 0..3 on the same edge with `evt_ready`=1 -> press events in id order 0,1,2,3 on consecutive cycles. Repeat the test with the pointer at 2 -> order 2,3,0,1.
- Hold `evt_ready`=0, then press and release button 3 twice -> first press is held on the output; release fills the slot; later posts produce `evt_drop` pulses. `evt_id`/`evt_type` stay stable.
- Assert `rst_n`=0 while `evt_valid`=1 and slots are full -> `evt_valid`=0 immediately. No stale events after reset is released.
